// File: rtl/wired_bus_pkg.sv
// Shared types and helpers for the wired-bus ownership arbiter.
// Supports up to MAX_N requesters.
package wired_bus_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req_vec at or above ptr, wrapping modulo n.
    // Returns the found flag; the winner index is returned through idx.
    function automatic logic rr_pick(input logic [MAX_N-1:0] req_vec,
                                     input int ptr,
                                     input int n,
                                     output int idx);
        logic hit;
        int   k;
        hit = 1'b0;
        idx = 0;
        // Walk offsets downward so the smallest offset from ptr wins.
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                k = ptr + i;
                if (k >= n) k = k - n;
                if (req_vec[k]) begin
                    hit = 1'b1;
                    idx = k;
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/wired_bus_arbiter_rr_pointer_pick.sv
// Combinational round-robin search: first requester at or after ptr.
module rr_pointer_pick
    import wired_bus_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = idx_w(N)
) (
    input  logic [W-1:0] ptr,
    input  logic [N-1:0] req,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [MAX_N-1:0] req_ext;
    logic             hit;
    int               idx_i;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        hit            = rr_pick(req_ext, int'(ptr), N, idx_i);
        // Range guard keeps a corrupt index from ever producing a grant.
        found          = hit && (idx_i >= 0) && (idx_i < N);
        winner         = W'(idx_i);
    end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state net: one-hot-or-zero
// driver enables with enforced undriven turnaround between owners.
module wired_bus_arbiter
    import wired_bus_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int TURN_CYCLES = 1,
    parameter  int MAX_TENURE  = 8,
    localparam int W           = idx_w(N),
    localparam int TW          = idx_w(MAX_TENURE + 1),
    localparam int CW          = idx_w(TURN_CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] owner,
    output logic         bus_idle,
    output logic         preempt
);

    localparam logic [TW-1:0] TEN_MAX   = TW'(MAX_TENURE);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [W-1:0]  PTR_LAST  = W'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  owner_q, owner_d;
    logic          idle_q, idle_d;
    logic          preempt_q, preempt_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [TW-1:0] tenure_q, tenure_d;
    logic [CW-1:0] turn_q, turn_d;

    logic [W-1:0]  winner;
    logic          found;
    logic          grant_now;
    logic          others_waiting;
    logic [TW-1:0] tenure_inc;

    rr_pointer_pick #(.N(N)) u_pick (
        .ptr    (ptr_q),
        .req    (req),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        owner_d        = owner_q;
        idle_d         = idle_q;
        preempt_d      = 1'b0;
        ptr_d          = ptr_q;
        tenure_d       = tenure_q;
        turn_d         = turn_q;
        grant_now      = 1'b0;
        tenure_inc     = (tenure_q == TEN_MAX) ? tenure_q : tenure_q + TW'(1);
        others_waiting = |(req & ~(N'(1) << owner_q));

        case (state_q)
            IDLE: begin
                if (found) grant_now = 1'b1;
            end
            GRANT: begin
                tenure_d = tenure_inc;
                if (!req[owner_q]) begin
                    state_d = TURN;
                    turn_d  = '0;
                    gnt_d   = '0;
                    idle_d  = 1'b1;
                end else if ((MAX_TENURE != 0) && (tenure_inc == TEN_MAX) && others_waiting) begin
                    state_d   = TURN;
                    turn_d    = '0;
                    gnt_d     = '0;
                    idle_d    = 1'b1;
                    preempt_d = 1'b1;
                end
            end
            TURN: begin
                // Arbitration happens only on the final undriven cycle.
                if (turn_q == TURN_LAST) begin
                    if (found) grant_now = 1'b1;
                    else       state_d   = IDLE;
                end else begin
                    turn_d = turn_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_now) begin
            state_d  = GRANT;
            gnt_d    = N'(1) << winner;
            owner_d  = winner;
            idle_d   = 1'b0;
            ptr_d    = (winner == PTR_LAST) ? '0 : winner + W'(1);
            tenure_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            idle_q    <= 1'b1;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            tenure_q  <= '0;
            turn_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            idle_q    <= idle_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            tenure_q  <= tenure_d;
            turn_q    <= turn_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_idle = idle_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Bench for wired_bus_arbiter: two instances (1 and 3 turnaround cycles)
// checked every cycle against an ownership-level reference model.
module tb_wired_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic       idle_a, idle_b, preempt_a, preempt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wired_bus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_TENURE(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a),
        .owner(owner_a), .bus_idle(idle_a), .preempt(preempt_a)
    );

    wired_bus_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_TENURE(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b),
        .owner(owner_b), .bus_idle(idle_b), .preempt(preempt_b)
    );

    // Model: who owns the bus, how long the current gap still lasts,
    // how many cycles the owner has held it, and the rotation start point.
    typedef struct {
        int owner;
        int gap;
        int held;
        int ptr;
        bit pre;
    } mstate_t;

    mstate_t m_a, m_b;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.owner = -1; s.gap = 0; s.held = 0; s.ptr = 0; s.pre = 0;
        return s;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic [3:0] r, int tc, int mt);
        mstate_t n;
        bit others;
        n = s;
        n.pre = 0;
        if (s.owner >= 0) begin
            n.held = s.held + 1;
            others = (r & ~(4'b0001 << s.owner)) != 4'b0000;
            if (!r[s.owner]) begin
                n.owner = -1; n.gap = tc;
            end else if (mt != 0 && n.held >= mt && others) begin
                n.owner = -1; n.gap = tc; n.pre = 1;
            end
        end else begin
            if (s.gap > 0) n.gap = s.gap - 1;
            if (n.gap == 0 && r != 4'b0000) begin
                for (int k = 3; k >= 0; k--)
                    if (r[(s.ptr + k) % 4]) n.owner = (s.ptr + k) % 4;
                n.held = 0;
                n.ptr  = (n.owner + 1) % 4;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input string tag, input mstate_t m, input logic [3:0] g,
                           input logic [1:0] o, input logic idl, input logic pre);
        logic [3:0] eg;
        eg = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
        chk({tag, "_gnt"}, int'(g), int'(eg));
        chk({tag, "_idle"}, int'(idl), (m.owner < 0) ? 1 : 0);
        chk({tag, "_preempt"}, int'(pre), int'(m.pre));
        chk({tag, "_onehot0"}, int'($onehot0(g)), 1);
        if (m.owner >= 0) chk({tag, "_owner"}, int'(o), m.owner);
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        m_a = m_step(m_a, req, 1, 8);
        m_b = m_step(m_b, req, 3, 8);
        @(negedge clk);
        cmp_one("a", m_a, gnt_a, owner_a, idle_a, preempt_a);
        cmp_one("b", m_b, gnt_b, owner_b, idle_b, preempt_b);
    endtask

    int owners[$];
    int runs[$];
    int gaps[$];
    int exp_own[5] = '{0, 1, 2, 3, 0};
    int run_len, gap_len, pre_cnt, hold_cnt;
    logic [3:0] prev;

    initial begin
        m_a = m_reset();
        m_b = m_reset();

        // Reset, then an idle bus for 10 cycles.
        rst = 1'b1; req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt_a), 0);
        chk("rst_idle", int'(idle_a), 1);
        chk("rst_owner", int'(owner_a), 0);
        chk("rst_preempt", int'(preempt_a), 0);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("idle_gnt", int'(gnt_a), 0);
            chk("idle_bus", int'(idle_a), 1);
        end

        // Two requesters from IDLE, then owner drops.
        req = 4'b0110; tick();
        chk("pair_first", int'(gnt_a), 4'b0010);
        req = 4'b0100; tick();
        chk("pair_turn", int'(gnt_a), 4'b0000);
        tick();
        chk("pair_second", int'(gnt_a), 4'b0100);
        req = 4'b0000;
        repeat (8) tick();

        // Three-cycle turnaround on instance b: owner 0 releases with req[2] pending.
        req = 4'b0001; tick();
        chk("tc3_own0", int'(gnt_b), 4'b0001);
        req = 4'b0101; tick();
        chk("tc3_hold0", int'(gnt_b), 4'b0001);
        req = 4'b0100;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("tc3_gap", int'(gnt_b), 4'b0000);
        end
        tick();
        chk("tc3_own2", int'(gnt_b), 4'b0100);
        req = 4'b0000;
        repeat (10) tick();

        // Sole requester keeps the bus with no preemption.
        req = 4'b1000; hold_cnt = 0; pre_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (gnt_a == 4'b1000) hold_cnt++;
            if (preempt_a) pre_cnt++;
        end
        chk("sole_hold_cycles", hold_cnt, 30);
        chk("sole_preempts", pre_cnt, 0);

        // Asynchronous reset between edges while driver 3 owns the bus.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt_a", int'(gnt_a), 0);
        chk("async_rst_gnt_b", int'(gnt_b), 0);
        chk("async_rst_idle", int'(idle_a), 1);
        m_a = m_reset();
        m_b = m_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;

        // Full contention: rotation 0,1,2,3,0 with 8-cycle tenures.
        prev = 4'b0000; run_len = 0; gap_len = 0; pre_cnt = 0;
        for (int t = 0; t < 46; t++) begin
            tick();
            if (t == 0) chk("post_rst_grant", int'(gnt_a), 4'b0001);
            if (gnt_a != 4'b0000) begin
                if (prev == 4'b0000) begin
                    owners.push_back(int'(owner_a));
                    if (gap_len > 0) gaps.push_back(gap_len);
                    gap_len = 0;
                end
                run_len++;
            end else begin
                if (prev != 4'b0000) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
                gap_len++;
            end
            if (preempt_a) pre_cnt++;
            prev = gnt_a;
        end
        chk("rot_owner_count", owners.size(), 6);
        for (int i = 0; i < 5 && i < owners.size(); i++) chk("rot_owner", owners[i], exp_own[i]);
        chk("rot_run_count", runs.size(), 5);
        foreach (runs[i]) chk("rot_tenure", runs[i], 8);
        chk("rot_gap_count", gaps.size(), 5);
        foreach (gaps[i]) chk("rot_gap", gaps[i], 1);
        chk("rot_preempts", pre_cnt, 5);

        // Randomised request levels, every cycle checked against the model.
        for (int t = 0; t < 2000; t++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
